instruction_fetch_unit: RTL

//  IF stage of the 5-stage MIPS pipeline; initiator side of the instruction ROM (word index = addr[9:2]).

---
 rtl/mips_pkg.sv | 24 ++
 rtl/instruction_fetch_unit_if.sv | 10 +
 rtl/pc_next_mux.sv | 51 +++++
 rtl/instruction_fetch_unit.sv | 116 +++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the IF stage: vector defaults, nop encoding and next-PC select.
package mips_pkg;

    localparam logic [31:0] RESET_VEC_DEF = 32'h8000_0000;
    localparam logic [31:0] IRQ_VEC_DEF   = 32'h8000_0004;
    localparam logic [31:0] EXC_VEC_DEF   = 32'h8000_0008;
    localparam logic [31:0] NOP_INSTR     = 32'h0000_0000;

    typedef enum logic [2:0] {
        SEL_SEQ,
        SEL_HOLD,
        SEL_JUMP,
        SEL_JR,
        SEL_BRANCH,
        SEL_IRQ,
        SEL_EXC
    } pc_sel_e;

    // Sequential increment leaves the kernel bit alone.
    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction ROM bus: the fetch unit drives the word address, the ROM answers in the same cycle.
interface instruction_fetch_unit_if;

    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;

    modport master (output imem_addr, input imem_rdata);
    modport slave  (input imem_addr, output imem_rdata);

endinterface

// File: rtl/pc_next_mux.sv
// Combinational next-PC priority select and redirect target formation for the IF stage.
module pc_next_mux
    import mips_pkg::*;
#(
    parameter logic [31:0] IRQ_VEC = IRQ_VEC_DEF,
    parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
    input  logic [31:0] pc,
    input  logic        stall,
    input  logic        jump,
    input  logic [25:0] jump_idx,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        irq,
    input  logic        exception,
    input  logic        slot_block,
    output pc_sel_e     sel,
    output logic [31:0] next_pc,
    output logic [31:0] pc_plus4
);

    logic irq_take;

    always_comb begin
        pc_plus4 = pc_inc(pc);
        // Level irq: any competing redirect or stall defers it to a later cycle.
        irq_take = irq & ~pc[31] & ~branch_taken & ~jump & ~jr & ~stall & ~slot_block;

        sel = SEL_SEQ;
        if (exception)         sel = SEL_EXC;
        else if (irq_take)     sel = SEL_IRQ;
        else if (branch_taken) sel = SEL_BRANCH;
        else if (stall)        sel = SEL_HOLD;
        else if (jr)           sel = SEL_JR;
        else if (jump)         sel = SEL_JUMP;

        next_pc = pc_plus4;
        unique case (sel)
            SEL_EXC:    next_pc = EXC_VEC;
            SEL_IRQ:    next_pc = IRQ_VEC;
            SEL_BRANCH: next_pc = branch_target;
            SEL_JR:     next_pc = jr_target;
            SEL_JUMP:   next_pc = {pc[31:28], jump_idx, 2'b00};
            SEL_HOLD:   next_pc = pc;
            default:    next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// IF stage: owns the PC and the IF/ID register, handles redirects and vector entry.
// Optional BRANCH_DELAY_SLOT_EN: ID jumps keep the sequential slot word instead of flushing it.
module instruction_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
    parameter logic [31:0] IRQ_VEC   = IRQ_VEC_DEF,
    parameter logic [31:0] EXC_VEC   = EXC_VEC_DEF
) (
    input  logic                     clk,
    input  logic                     reset,
    instruction_fetch_unit_if.master imem,
    input  logic                     stall,
    input  logic                     jump,
    input  logic [25:0]              jump_idx,
    input  logic                     jr,
    input  logic [31:0]              jr_target,
    input  logic                     branch_taken,
    input  logic [31:0]              branch_target,
    input  logic                     irq,
    input  logic                     exception,
    output logic [31:0]              ifid_instr,
    output logic [31:0]              ifid_pc,
    output logic [31:0]              ifid_pc_plus4,
    output logic                     ifid_valid,
    output logic [31:0]              epc,
    output logic                     epc_we
);

    logic [31:0] pc;
    logic [31:0] next_pc;
    logic [31:0] pc_plus4;
    pc_sel_e     sel;
    logic        slot_block;
    logic        do_flush;
    logic        do_load;
    logic        do_vector;

    assign imem.imem_addr = pc;

    pc_next_mux #(
        .IRQ_VEC (IRQ_VEC),
        .EXC_VEC (EXC_VEC)
    ) u_pc_next_mux (
        .pc            (pc),
        .stall         (stall),
        .jump          (jump),
        .jump_idx      (jump_idx),
        .jr            (jr),
        .jr_target     (jr_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .irq           (irq),
        .exception     (exception),
        .slot_block    (slot_block),
        .sel           (sel),
        .next_pc       (next_pc),
        .pc_plus4      (pc_plus4)
    );

    always_comb begin
        do_vector = (sel == SEL_EXC) || (sel == SEL_IRQ);
        do_flush  = do_vector || (sel == SEL_BRANCH);
        do_load   = (sel == SEL_SEQ);
`ifdef BRANCH_DELAY_SLOT_EN
        do_load   = do_load || (sel == SEL_JUMP) || (sel == SEL_JR);
`else
        do_flush  = do_flush || (sel == SEL_JUMP) || (sel == SEL_JR);
`endif
    end

`ifdef BRANCH_DELAY_SLOT_EN
    logic slot_q;

    // Tracks whether IF/ID currently holds the delay-slot word of a taken jump.
    always_ff @(posedge clk) begin
        if (reset)
            slot_q <= 1'b0;
        else if (sel != SEL_HOLD)
            slot_q <= (sel == SEL_JUMP) || (sel == SEL_JR);
    end

    assign slot_block = slot_q;
`else
    assign slot_block = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= RESET_VEC;
            ifid_instr    <= '0;
            ifid_pc       <= '0;
            ifid_pc_plus4 <= '0;
            ifid_valid    <= 1'b0;
            epc           <= '0;
            epc_we        <= 1'b0;
        end else begin
            pc     <= next_pc;
            epc_we <= do_vector;
            if (do_vector)
                epc <= ifid_valid ? ifid_pc : pc;
            if (do_flush) begin
                ifid_instr    <= NOP_INSTR;
                ifid_pc       <= '0;
                ifid_pc_plus4 <= '0;
                ifid_valid    <= 1'b0;
            end else if (do_load) begin
                ifid_instr    <= imem.imem_rdata;
                ifid_pc       <= pc;
                ifid_pc_plus4 <= pc_plus4;
                ifid_valid    <= 1'b1;
            end
        end
    end

endmodule
